pulse_meter: RTL and testbench
==============================

Name: pulse_meter

Overview:
Measures an incoming pulse train and reports the pulse width and pulse period in system clock cycles. The encoding matches the pulse generator configuration words, so a generator set to width W and period P reads back as width W and period P. It sits on the return path for loopback and self-test of the OTDR launch pulse. It also monitors externally supplied trigger trains and flags missing, stuck or out-of-range pulses.

Parameters:
CNT_WIDTH, 8, width of the measurement counters and result words.
SYNC_STAGES, 2, flip-flop stages of the pulse_in synchronizer (minimum 2).
LOCK_COUNT, 4, consecutive identical measurements required to assert locked (1..15).

Ports:
clock  input  1  system clock.
reset_async  input  1  asynchronous reset, active high.
enable  input  1  1 = measure; 0 = hold in IDLE.
pulse_in  input  1  pulse train under test, may be asynchronous to clock.
err_clear  input  1  single-cycle pulse that clears the sticky error flags.
meas_width  output  CNT_WIDTH  high time of the last complete period, in cycles.
meas_period  output  CNT_WIDTH  rise-to-rise cycles minus 1 of the last complete period.
meas_valid  output  1  one-cycle strobe; meas_width and meas_period updated this cycle.
locked  output  1  LOCK_COUNT consecutive identical measurements seen.
err_timeout  output  1  sticky: no edge for 2^CNT_WIDTH cycles (stuck high or stuck low).
err_range  output  1  sticky: period too long to represent.

Behaviour:
- Reset: all outputs 0, synchronizer flops 0, state IDLE, counters 0, lock counter 0.
- pulse_in passes through the SYNC_STAGES synchronizer. Rise and fall are detected on the synchronized signal, with one previous-sample register.
- States:
  - IDLE: entered on reset or when enable=0 (from any state, next cycle). Clears counters, the lock counter and locked. Holds meas_width and meas_period. Goes to SEEK when enable=1.
  - SEEK: discards any partial pulse. On rise, goes to HIGH with the counter restarted.
  - HIGH: counts cycles while the synchronized input is 1. On fall, latches the width into an internal register and goes to LOW.
  - LOW: keeps counting from the rise. On rise, publishes the result and goes to HIGH with the counter restarted.
- Counting rules:
  - width = number of synchronized samples that are high.
  - period_cycles = number of samples from one rise to the next rise.
  - meas_period = period_cycles - 1.
  - Example: generator W=3, P=9 gives 3 high and 7 low samples, so the bench reads meas_width=3 and meas_period=9.
- Publish, on the rise in LOW:
  - meas_width and meas_period update and meas_valid=1 for exactly that cycle.
  - Latency: meas_valid is high SYNC_STAGES+1 clocks after the first clock edge that samples pulse_in high.
  - The first period after SEEK is published; the partial pulse before the first rise is never published.
- Timeout:
  - If the counter reaches 2^CNT_WIDTH-1 in HIGH without a fall, set err_timeout and go to SEEK.
  - If no rise arrives within 2^CNT_WIDTH cycles in SEEK, set err_timeout and stay in SEEK.
  - Covers generator W=0 (constant low) and W>P (constant high).
- Range: if the counter would pass 2^CNT_WIDTH-1 in LOW, set err_range, do not publish, and go to SEEK. period_cycles = 2^CNT_WIDTH is legal (meas_period = all ones).
- Counters never wrap: the checks above fire before any wrap.
- Lock:
  - The lock counter increments on each publish whose width and period equal the previous published pair.
  - A differing pair reloads the lock counter to 1.
  - locked=1 while the lock counter ≥ LOCK_COUNT, updating in the same cycle as meas_valid.
  - Any error event, or enable=0, clears locked and the lock counter.
- Sticky errors:
  - Cleared only by err_clear or reset.
  - If err_clear and a new error event occur in the same cycle, the flag ends set.
  - err_clear does not affect the measurement state.
- Reset asserted mid-pulse returns to IDLE immediately. After release, the next published value comes from a full period following a fresh rise.

Test Plan:
- Generator W=3, P=9, enable=1 -> meas_valid every 10 cycles with width=3, period=9; locked rises on the 4th valid; no errors.
- W=255, P=255 (255 high, 1 low) -> width=255, period=255 every 256 cycles; err_range and err_timeout stay 0.
- pulse_in held 0 -> no meas_valid; err_timeout=1 after 256 cycles in SEEK; err_clear pulse -> err_timeout=0, and it sets again 256 cycles later.
- pulse_in held 1 after one rise -> err_timeout in HIGH, state returns to SEEK; locked drops the same cycle; earlier meas values are held.
- Locked at W=3, P=9, then switch to W=5, P=20 -> first new valid reads 5/20 with locked=0; locked=1 again on the 4th identical valid.
- enable deasserted mid-HIGH, or reset_async pulsed mid-LOW -> no meas_valid from the interrupted period; all outputs 0 after reset. The first valid after restart is a complete, correct period.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: measures pulse width and rise-to-rise period of a pulse train.
// Ports: clock, reset_async, enable, pulse_in, err_clear in;
//        meas_width/period/valid, locked, err_timeout/err_range out.
module pulse_meter #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clock,
  input  logic                 reset_async,
  input  logic                 enable,
  input  logic                 pulse_in,
  input  logic                 err_clear,
  output logic [CNT_WIDTH-1:0] meas_width,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 err_timeout,
  output logic                 err_range
);

  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_e;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [3:0] lock_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_HI  = CNT_MAX - cnt_t'(1);
  localparam lock_t LOCK_N = lock_t'(LOCK_COUNT);

  // Sync chain + sample + previous-sample registers hold reset zeros
  // for FILL edges; leaving IDLE earlier could see a false rise.
  localparam int FILL = SYNC_STAGES + 1;
  localparam int FW   = $clog2(FILL + 1);
  typedef logic [FW-1:0] fill_t;
  localparam fill_t FILL_N = fill_t'(FILL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic   smp_q, prev_q;
  fill_t  fill_q;
  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   wid_q, wid_d;
  cnt_t   mw_q, mw_d;
  cnt_t   mp_q, mp_d;
  logic   mv_q, mv_d;
  lock_t  lock_q, lock_d;
  logic   locked_q, locked_d;
  logic   to_q, to_d;
  logic   rg_q, rg_d;

  logic  rise, fall, fill_done;
  logic  to_ev, rg_ev;
  cnt_t  cnt_inc;
  lock_t lock_inc;

  assign rise      = smp_q & ~prev_q;
  assign fall      = ~smp_q & prev_q;
  assign fill_done = (fill_q == FILL_N);
  assign cnt_inc   = cnt_q + cnt_t'(1);
  assign lock_inc  = (lock_q == 4'hF) ? lock_q
                   : lock_q + lock_t'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    mw_d    = mw_q;
    mp_d    = mp_q;
    mv_d    = 1'b0;
    lock_d  = lock_q;
    to_ev   = 1'b0;
    rg_ev   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      lock_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d  = '0;
          lock_d = '0;
          if (fill_done) state_d = SEEK;
        end
        SEEK: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            to_ev = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HIGH: begin
          // cnt_q is samples since the rise minus one
          if (fall) begin
            wid_d   = cnt_inc;
            cnt_d   = cnt_inc;
            state_d = LOW;
          end else if (cnt_q == CNT_HI) begin
            to_ev   = 1'b1;
            cnt_d   = '0;
            state_d = SEEK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            mv_d    = 1'b1;
            mw_d    = wid_q;
            mp_d    = cnt_q;
            cnt_d   = '0;
            state_d = HIGH;
            lock_d  = (wid_q == mw_q && cnt_q == mp_q)
                    ? lock_inc : lock_t'(1);
          end else if (cnt_q == CNT_MAX) begin
            rg_ev   = 1'b1;
            cnt_d   = '0;
            state_d = SEEK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
    if (to_ev || rg_ev) lock_d = '0;
    locked_d = (lock_d >= LOCK_N);
    to_d     = to_ev | (to_q & ~err_clear);
    rg_d     = rg_ev | (rg_q & ~err_clear);
  end

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      sync_q   <= '0;
      smp_q    <= 1'b0;
      prev_q   <= 1'b0;
      fill_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      wid_q    <= '0;
      mw_q     <= '0;
      mp_q     <= '0;
      mv_q     <= 1'b0;
      lock_q   <= '0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
      rg_q     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      smp_q    <= sync_q[SYNC_STAGES-1];
      prev_q   <= smp_q;
      if (!fill_done) fill_q <= fill_q + fill_t'(1);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wid_q    <= wid_d;
      mw_q     <= mw_d;
      mp_q     <= mp_d;
      mv_q     <= mv_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      to_q     <= to_d;
      rg_q     <= rg_d;
    end
  end

  assign meas_width  = mw_q;
  assign meas_period = mp_q;
  assign meas_valid  = mv_q;
  assign locked      = locked_q;
  assign err_timeout = to_q;
  assign err_range   = rg_q;

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed + random pulse trains against a sample-level model.
// Ports: drives every pulse_meter port; prints one summary line.
module tb_pulse_meter;

  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int LC  = 4;
  localparam int LAT = SS + 1;
  localparam int TOP = 2 ** CW;

  logic clock = 1'b0;
  logic reset_async, enable, pulse_in, err_clear;
  logic [CW-1:0] meas_width, meas_period;
  logic meas_valid, locked, err_timeout, err_range;

  int checks = 0;
  int errors = 0;

  pulse_meter #(
    .CNT_WIDTH(CW),
    .SYNC_STAGES(SS),
    .LOCK_COUNT(LC)
  ) dut (
    .clock(clock),
    .reset_async(reset_async),
    .enable(enable),
    .pulse_in(pulse_in),
    .err_clear(err_clear),
    .meas_width(meas_width),
    .meas_period(meas_period),
    .meas_valid(meas_valid),
    .locked(locked),
    .err_timeout(err_timeout),
    .err_range(err_range)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int w;
    int p;
  } pub_t;

  pub_t pq[$];
  int   ecnt = 0;
  bit   prevv, has_rise;
  int   rise_at, hi_cnt, run;
  int   exp_w, exp_p;
  bit   exp_v, exp_lk, exp_to, exp_rg;
  int   err_edge = -1;
  bit   err_is_rg;
  bit   seek_on;
  int   seek_start;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d",
             tag, ecnt, obs, exp);
    end
  endtask

  task automatic check_outs(input string t);
    chk({t, " valid"}, {31'b0, meas_valid}, {31'b0, exp_v});
    chk({t, " width"}, {24'b0, meas_width}, 32'(exp_w));
    chk({t, " period"}, {24'b0, meas_period}, 32'(exp_p));
    chk({t, " locked"}, {31'b0, locked}, {31'b0, exp_lk});
    chk({t, " err_timeout"}, {31'b0, err_timeout}, {31'b0, exp_to});
    chk({t, " err_range"}, {31'b0, err_range}, {31'b0, exp_rg});
  endtask

  task automatic model_reset();
    pq.delete();
    has_rise = 0;
    run      = 0;
    exp_w    = 0;
    exp_p    = 0;
    exp_v    = 0;
    exp_lk   = 0;
    exp_to   = 0;
    exp_rg   = 0;
  endtask

  // One clock: drive a sample, update the model, compare at negedge.
  task automatic cyc(input logic v);
    pub_t e;
    bit ev_to, ev_rg;
    pulse_in = v;
    @(posedge clock);
    ecnt++;
    exp_v = 0;
    if (enable && v && !prevv) begin
      if (has_rise) begin
        e.due = ecnt + LAT;
        e.w   = hi_cnt;
        e.p   = ecnt - rise_at - 1;
        pq.push_back(e);
      end
      has_rise = 1;
      rise_at  = ecnt;
      hi_cnt   = 0;
    end
    if (v) hi_cnt++;
    prevv = v;
    ev_to = (ecnt == err_edge) && !err_is_rg;
    ev_rg = (ecnt == err_edge) && err_is_rg;
    if (seek_on && ecnt > seek_start
        && (ecnt - seek_start) % TOP == 0) ev_to = 1;
    if (!enable) begin
      run      = 0;
      exp_lk   = 0;
      has_rise = 0;
      pq.delete();
    end
    if (pq.size() > 0 && pq[0].due == ecnt) begin
      e = pq.pop_front();
      if (run > 0 && e.w == exp_w && e.p == exp_p) run++;
      else run = 1;
      exp_w  = e.w;
      exp_p  = e.p;
      exp_v  = 1;
      exp_lk = (run >= LC);
    end
    if (ev_to || ev_rg) begin
      run      = 0;
      exp_lk   = 0;
      has_rise = 0;
    end
    exp_to = ev_to | (exp_to & ~err_clear);
    exp_rg = ev_rg | (exp_rg & ~err_clear);
    @(negedge clock);
    check_outs("cyc");
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic train(input int w, input int p, input int n);
    repeat (n) begin
      repeat (w) cyc(1'b1);
      repeat (p + 1 - w) cyc(1'b0);
    end
  endtask

  initial begin
    int w, p, n;
    reset_async = 1'b1;
    enable      = 1'b0;
    pulse_in    = 1'b0;
    err_clear   = 1'b0;
    prevv       = 0;
    model_reset();

    repeat (2) @(posedge clock);
    #2;
    check_outs("reset");
    @(negedge clock);
    reset_async = 1'b0;
    enable      = 1'b1;
    idle(10);

    // Basic W=3 P=9, lock on 4th valid
    train(3, 9, 6);

    // Random trains
    for (int s = 0; s < 6; s++) begin
      w = $urandom_range(12, 1);
      p = $urandom_range(30, w);
      n = $urandom_range(5, 1);
      train(w, p, n);
    end

    // Lock then switch
    train(3, 9, 5);
    train(5, 20, 5);

    // Widest legal pulse and period
    train(255, 255, 3);

    // Enable dropped mid-HIGH
    train(3, 9, 3);
    repeat (4) cyc(1'b1);
    enable = 1'b0;
    repeat (2) cyc(1'b1);
    repeat (6) cyc(1'b0);
    enable = 1'b1;
    idle(8);
    train(3, 9, 5);

    // Reset mid-LOW, released with pulse_in high
    train(3, 9, 2);
    repeat (3) cyc(1'b1);
    repeat (6) cyc(1'b0);
    #2;
    reset_async = 1'b1;
    pulse_in    = 1'b1;
    model_reset();
    prevv = 1;
    #1;
    check_outs("reset_mid");
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_async = 1'b0;
    repeat (6) cyc(1'b1);
    repeat (6) cyc(1'b0);
    train(3, 9, 5);

    // Held low in LOW: range error
    err_edge  = rise_at + LAT + TOP;
    err_is_rg = 1;
    idle(270);
    err_clear = 1'b1;
    cyc(1'b0);
    err_clear = 1'b0;

    // Held high after a rise: timeout in HIGH
    train(3, 9, 5);
    err_edge  = ecnt + 1 + LAT + TOP - 1;
    err_is_rg = 0;
    repeat (270) cyc(1'b1);
    err_clear = 1'b1;
    cyc(1'b0);
    err_clear = 1'b0;
    idle(5);

    // Held low in SEEK: repeating timeout, clear collisions
    enable = 1'b0;
    repeat (3) cyc(1'b0);
    enable     = 1'b1;
    seek_on    = 1;
    seek_start = ecnt + 1;
    for (int k = 0; k < 540; k++) begin
      err_clear = (k == 300 || k == 512 || k == 530);
      cyc(1'b0);
    end
    err_clear = 1'b0;
    seek_on   = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
